// File: rtl/lfsr_seq_pkg.sv
// lfsr_seq_pkg: sequencer states, the six LFSR tap patterns and shared byte constants.
package lfsr_seq_pkg;
   typedef enum logic [3:0] {IDLE, SEED, LOAD, TRAIN, CHECK, RELOAD, RUN, PAD, DONE} state_t;
   localparam int NTAPS_DEF = 6;
   localparam logic [5:0] TAP_PTRN [NTAPS_DEF] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};
   localparam logic [7:0] PRE_CHAR_DEF = 8'h5F;
   localparam logic [7:0] PAD_CHAR = 8'h20;
endpackage

// File: rtl/lfsr_decrypt_seq_mask.sv
// lfsr_match_mask: per-lane state compare, surviving-candidate mask and lowest-index tap select.
module lfsr_match_mask #(
   parameter int LW    = 6,
   parameter int NTAPS = 6
) (
   input  logic                clk,
   input  logic                init_n,
   input  logic                i_clr,
   input  logic                i_en,
   input  logic                i_latch,
   input  logic [NTAPS*LW-1:0] i_lanes,
   input  logic [LW-1:0]       i_exp,
   output logic [NTAPS-1:0]    o_mask,
   output logic [2:0]          o_tap_sel
);
   logic [NTAPS-1:0] r_mask, w_hit;
   logic [2:0]       w_low;

   always_comb begin
      for (int i = 0; i < NTAPS; i++) w_hit[i] = i_lanes[i*LW +: LW] == i_exp;
   end

   assign o_mask = i_en ? (r_mask & w_hit) : r_mask;

   always_comb begin
      w_low = '0;
      for (int i = NTAPS - 1; i >= 0; i--) if (o_mask[i]) w_low = 3'(i);
   end

   always_ff @(posedge clk) begin
      if (!init_n || i_clr) r_mask <= '1;
      else r_mask <= o_mask;
      if (!init_n) o_tap_sel <= '0;
      else if (i_latch) o_tap_sel <= w_low;
   end
endmodule

// File: rtl/lfsr_decrypt_seq.sv
// lfsr_decrypt_seq: recovers seed and tap pattern from the known preamble, then decrypts to memory.
// Define LFSR_SEQ_STRIP_PREAMBLE_EN to drop leading preamble bytes and space-pad the tail.
module lfsr_decrypt_seq
   import lfsr_seq_pkg::*;
#(
   parameter int          AW       = 8,
   parameter int          LW       = 6,
   parameter int          NTAPS    = 6,
   parameter int          SRC_BASE = 64,
   parameter int          DST_BASE = 0,
   parameter int          MSG_LEN  = 64,
   parameter int          PRE_LEN  = 7,
   parameter logic [7:0]  PRE_CHAR = PRE_CHAR_DEF
) (
   input  logic                clk,
   input  logic                init_n,
   input  logic                start,
   input  logic [7:0]          data_out,
   input  logic [NTAPS*LW-1:0] lfsr_state,
   output logic [AW-1:0]       raddr,
   output logic [AW-1:0]       waddr,
   output logic                wr_en,
   output logic [7:0]          data_in,
   output logic                load_lfsr,
   output logic                lfsr_en,
   output logic [LW-1:0]       seed,
   output logic [2:0]          tap_sel,
   output logic                busy,
   output logic                done,
   output logic                err
);
   localparam int              CW       = $clog2(MSG_LEN + 1);
   localparam logic [AW-1:0]   SRC      = AW'(SRC_BASE);
   localparam logic [AW-1:0]   DST      = AW'(DST_BASE);
   localparam logic [CW-1:0]   PRE_LAST = CW'(PRE_LEN - 1);
   localparam logic [CW-1:0]   MSG_LAST = CW'(MSG_LEN - 1);

   state_t           r_state, w_next;
   logic [CW-1:0]    r_cnt;
   logic [LW-1:0]    r_exp, r_seed, w_exp_in, w_lane;
   logic             r_err, r_done, w_none;
   logic [NTAPS-1:0] w_mask;
   logic [7:0]       w_dec;
   logic [AW-1:0]    w_addr_c;

   assign w_exp_in = data_out[LW-1:0] ^ PRE_CHAR[LW-1:0];
   assign w_lane   = lfsr_state[tap_sel*LW +: LW];
   assign w_dec    = data_out ^ 8'(w_lane);
   assign w_none   = ~|w_mask;
   assign w_addr_c = SRC + AW'(r_cnt);
   assign seed     = r_seed;
   assign err      = r_err;
   assign done     = r_done;
   assign busy     = r_state != IDLE && r_state != DONE;

   lfsr_match_mask #(.LW(LW), .NTAPS(NTAPS)) u_mask (
      .clk       (clk),
      .init_n    (init_n),
      .i_clr     (r_state == LOAD),
      .i_en      (r_state == TRAIN || r_state == CHECK),
      .i_latch   (r_state == CHECK),
      .i_lanes   (lfsr_state),
      .i_exp     (r_exp),
      .o_mask    (w_mask),
      .o_tap_sel (tap_sel)
   );

`ifdef LFSR_SEQ_STRIP_PREAMBLE_EN
   logic          r_strip, w_keep;
   logic [CW-1:0] r_wp;

   assign w_keep = !(r_strip && w_dec == PRE_CHAR);

   always_ff @(posedge clk) begin
      if (!init_n || r_state == RELOAD) begin
         r_strip <= 1'b1;
         r_wp    <= '0;
      end else if (wr_en) begin
         r_strip <= 1'b0;
         r_wp    <= r_wp + CW'(1);
      end
   end
`endif

   always_comb begin
      w_next    = r_state;
      raddr     = SRC;
      waddr     = DST;
      wr_en     = 1'b0;
      load_lfsr = 1'b0;
      lfsr_en   = 1'b0;
      data_in   = w_dec;
      case (r_state)
         IDLE:    w_next = start ? SEED : IDLE;
         SEED:    w_next = LOAD;
         LOAD: begin
            load_lfsr = 1'b1;
            w_next    = TRAIN;
         end
         TRAIN: begin
            raddr   = w_addr_c;
            lfsr_en = 1'b1;
            w_next  = (r_cnt == PRE_LAST) ? CHECK : TRAIN;
         end
         CHECK:   w_next = w_none ? DONE : RELOAD;
         RELOAD: begin
            load_lfsr = 1'b1;
            w_next    = RUN;
         end
`ifdef LFSR_SEQ_STRIP_PREAMBLE_EN
         RUN: begin
            raddr   = w_addr_c;
            lfsr_en = 1'b1;
            wr_en   = w_keep;
            waddr   = DST + AW'(r_wp);
            w_next  = (r_cnt != MSG_LAST) ? RUN :
                      (r_wp + CW'(w_keep) == CW'(MSG_LEN)) ? DONE : PAD;
         end
         PAD: begin
            wr_en   = 1'b1;
            waddr   = DST + AW'(r_wp);
            data_in = PAD_CHAR;
            w_next  = (r_wp == MSG_LAST) ? DONE : PAD;
         end
`else
         RUN: begin
            raddr   = w_addr_c;
            waddr   = DST + AW'(r_cnt);
            wr_en   = 1'b1;
            lfsr_en = 1'b1;
            w_next  = (r_cnt == MSG_LAST) ? DONE : RUN;
         end
`endif
         DONE:    w_next = DONE;
         default: w_next = IDLE;
      endcase
      // reset must suppress any write or LFSR action in the aborting cycle
      if (!init_n) begin
         raddr     = SRC;
         waddr     = DST;
         wr_en     = 1'b0;
         load_lfsr = 1'b0;
         lfsr_en   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!init_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_seed  <= '0;
         r_exp   <= '0;
         r_err   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_exp   <= w_exp_in;
         r_cnt   <= (r_state == LOAD) ? CW'(1) :
                    (r_state == RELOAD) ? CW'(0) :
                    (r_state == TRAIN || r_state == RUN) ? r_cnt + CW'(1) : r_cnt;
         if (r_state == SEED) r_seed <= w_exp_in;
         if (r_state == CHECK && w_none) r_err <= 1'b1;
         r_done  <= r_state == DONE;
      end
   end
endmodule

// File: tb/tb_lfsr_decrypt_seq.sv
// tb_lfsr_decrypt_seq: memory and LFSR-bank environment, plaintext/encryption model and
// write-stream scoreboard for the decrypt sequencer.
module tb_lfsr_decrypt_seq;
   import lfsr_seq_pkg::*;
   localparam int AW = 8, LW = 6, NT = 6, SRC = 64, DST = 0, ML = 64, PL = 7;
   localparam logic [7:0] PC = 8'h5F;
`ifdef LFSR_SEQ_STRIP_PREAMBLE_EN
   localparam bit STRIP = 1'b1;
`else
   localparam bit STRIP = 1'b0;
`endif

   typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;

   logic clk = 1'b0, init_n = 1'b0, start = 1'b0;
   logic [7:0] data_out, data_in;
   logic [NT*LW-1:0] lfsr_state;
   logic [AW-1:0] raddr, waddr;
   logic wr_en, load_lfsr, lfsr_en, busy, done, err;
   logic [LW-1:0] seed;
   logic [2:0] tap_sel;

   logic [7:0] mem [256];
   logic [LW-1:0] lane [NT];
   logic tb_we = 1'b0;
   logic [7:0] tb_a, tb_d;
   int n_wr;

   int checks = 0, failures = 0;
   int mon_c = 0, dc = 0, exp_tap = 0, n = 0;
   bit mon_on = 1'b0, exp_ok = 1'b0;
   logic [7:0] pt [ML], enc [ML], img [ML];
   wr_t expq [$];
   wr_t e;

   lfsr_decrypt_seq dut (
      .clk(clk), .init_n(init_n), .start(start), .data_out(data_out), .lfsr_state(lfsr_state),
      .raddr(raddr), .waddr(waddr), .wr_en(wr_en), .data_in(data_in), .load_lfsr(load_lfsr),
      .lfsr_en(lfsr_en), .seed(seed), .tap_sel(tap_sel), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] step(input logic [5:0] s, input logic [5:0] t);
      return {s[4:0], ^(s & t)};
   endfunction

   assign data_out = mem[raddr];
   always_comb begin
      for (int i = 0; i < NT; i++) lfsr_state[i*LW +: LW] = lane[i];
   end

   always @(posedge clk) begin
      if (tb_we) begin
         mem[tb_a] <= tb_d;
         n_wr <= 0;
      end else if (wr_en) begin
         mem[waddr] <= data_in;
         n_wr <= n_wr + 1;
      end
      for (int i = 0; i < NT; i++)
         if (load_lfsr) lane[i] <= seed;
         else if (lfsr_en) lane[i] <= step(lane[i], TAP_PTRN[i]);
   end

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // lowest pattern whose sequence from the recovered seed reproduces every preamble byte
   function automatic int find_tap();
      logic [5:0] s0, s;
      bit ok;
      s0 = enc[0][5:0] ^ 6'(PC);
      for (int i = 0; i < NT; i++) begin
         ok = 1'b1;
         s = s0;
         for (int k = 0; k < PL; k++) begin
            if (s != (enc[k][5:0] ^ 6'(PC))) ok = 1'b0;
            s = step(s, TAP_PTRN[i]);
         end
         if (ok) return i;
      end
      return -1;
   endfunction

   task automatic prep(input int ti, input logic [5:0] sv, input bit corrupt, input int lead);
      logic [5:0] s;
      logic [39:0] hello;
      int w;
      hello = "HELLO";
      s = sv;
      for (int j = 0; j < ML; j++) begin
         if (j < lead) pt[j] = PC;
         else if (j < lead + 5) pt[j] = hello[8*(4-(j-lead)) +: 8];
         else pt[j] = 8'(8'h61 + (j * 7 + ti) % 26);
         enc[j] = pt[j] ^ {2'b00, s};
         s = step(s, TAP_PTRN[ti]);
      end
      if (corrupt) enc[3] = enc[3] ^ 8'h20;
      exp_tap = find_tap();
      exp_ok = exp_tap >= 0;
      dc = exp_ok ? PL + 3 + ML + 1 : PL + 3;
      expq.delete();
      for (int j = 0; j < ML; j++) img[j] = 8'hAA;
      w = 0;
      if (exp_ok) begin
         for (int j = 0; j < ML; j++)
            if (!STRIP || w > 0 || pt[j] != PC) begin
               expq.push_back('{a: 8'(DST + w), d: pt[j]});
               img[w] = pt[j];
               w++;
            end
         for (; w < ML; w++) begin
            expq.push_back('{a: 8'(DST + w), d: 8'h20});
            img[w] = 8'h20;
         end
      end
      init_n = 1'b0;
      tb_we = 1'b1;
      for (int a = 0; a < 256; a++) begin
         tb_a = 8'(a);
         tb_d = (a >= SRC && a < SRC + ML) ? enc[a - SRC] : (a >= DST && a < DST + ML) ? 8'hAA : 8'h00;
         @(posedge clk); #1;
      end
      tb_we = 1'b0;
      @(posedge clk); #1;
      init_n = 1'b1;
      #1;
   endtask

   task automatic run(input bit hold, output int cyc);
      start = 1'b1;
      @(posedge clk); #1;
      start = hold;
      mon_c = 0;
      mon_on = 1'b1;
      cyc = 0;
      while (!done && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("done_reached", done, 1);
      repeat (hold ? 20 : 3) @(posedge clk);
      #1;
      mon_on = 1'b0;
      start = 1'b0;
   endtask

   task automatic check_img();
      for (int j = 0; j < ML; j++) chk($sformatf("dst_mem[%0d]", j), mem[DST + j], img[j]);
      chk("all_writes_seen", expq.size(), 0);
   endtask

   always @(negedge clk) if (mon_on) begin
`ifndef LFSR_SEQ_STRIP_PREAMBLE_EN
      chk("busy", busy, int'(mon_c <= dc - 2));
      chk("done", done, int'(mon_c >= dc));
      chk("wr_en", wr_en, int'(exp_ok && mon_c >= PL + 3 && mon_c < PL + 3 + ML));
`endif
      if (wr_en) begin
         chk("write_expected", int'(expq.size() > 0), 1);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("waddr", waddr, e.a);
            chk("data_in", data_in, e.d);
         end
      end
      mon_c++;
   end

   initial begin
      prep(1, 6'h15, 1'b0, 7);
      chk("rst_raddr", raddr, SRC);
      chk("rst_waddr", waddr, DST);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_load", load_lfsr, 0);
      chk("rst_lfsr_en", lfsr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_tap_sel", tap_sel, 0);
      chk("rst_seed", seed, 0);
      chk("enc0_pin", mem[SRC], 8'h4A);
      chk("enc1_pin", mem[SRC + 1], 8'h75);
      chk("model_tap_pin", exp_tap, 1);
      run(1'b0, n);
`ifndef LFSR_SEQ_STRIP_PREAMBLE_EN
      chk("done_cycle", n, 75);
`endif
      chk("tap_sel_2d", tap_sel, 1);
      chk("seed_15", seed, 6'h15);
      chk("err_ok", err, 0);
      check_img();

      for (int i = 0; i < NT; i++) begin
         prep(i, 6'h01, 1'b0, 7);
         run(1'b0, n);
         chk($sformatf("tap_sel_pat%0d", i), tap_sel, i);
         chk("tap_sel_model", tap_sel, exp_tap);
         chk("err_pat", err, 0);
         check_img();
      end

      prep(1, 6'h15, 1'b1, 7);
      chk("model_no_tap", exp_tap, -1);
      run(1'b0, n);
      chk("err_done_cycle", n, 10);
      chk("err_set", err, 1);
      chk("err_no_writes", n_wr, 0);
      check_img();

      prep(1, 6'h15, 1'b0, 7);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mon_c = 0;
      mon_on = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      mon_on = 1'b0;
      init_n = 1'b0;
      #1;
      chk("wr_en_in_reset", wr_en, 0);
      @(posedge clk); #1;
      init_n = 1'b1;
      #1;
      chk("busy_after_reset", busy, 0);
      chk("wr_en_after_reset", wr_en, 0);
      chk("raddr_after_reset", raddr, SRC);
      repeat (5) @(posedge clk);
      #1;
      for (int j = 21; j < ML; j++) chk($sformatf("untouched[%0d]", j), mem[DST + j], 8'hAA);
`ifndef LFSR_SEQ_STRIP_PREAMBLE_EN
      chk("writes_before_reset", n_wr, 20);
      for (int j = 0; j < 20; j++) chk($sformatf("partial[%0d]", j), mem[DST + j], pt[j]);
`endif

      prep(1, 6'h15, 1'b0, 7);
      run(1'b1, n);
      chk("hold_single_run_writes", n_wr, ML);
      chk("hold_done", done, 1);
      chk("hold_busy", busy, 0);
      check_img();

`ifdef LFSR_SEQ_STRIP_PREAMBLE_EN
      prep(1, 6'h15, 1'b0, 10);
      run(1'b0, n);
      check_img();
      chk("strip_H", mem[DST], 8'h48);
      chk("strip_O", mem[DST + 4], 8'h4F);
      chk("strip_tail", mem[DST + ML - 1], 8'h20);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
